// File: rtl/fir_pkg.sv
// fir_pkg -- shared definitions for the FIR error calculator.
//   fir_state_t : 2-bit FSM state encoding (IDLE, MAC, ERR, UPD)
//   ACC_W       : accumulator width (50 bits holds 16 x 46-bit products)
//   SAT_MAX/MIN : 32-bit signed saturation limits
//   fir_reduce  : narrows a 50-bit signed value to 32 bits, either
//                 saturating (FIR_ERR_SAT_EN defined) or wrapping (default).
package fir_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_ERR  = 2'd2,
        S_UPD  = 2'd3
    } fir_state_t;

    localparam int          ACC_W   = 50;
    localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_MIN = 32'h8000_0000;

    function automatic logic [31:0] fir_reduce(input logic [ACC_W-1:0] v);
`ifdef FIR_ERR_SAT_EN
        // Value fits in 32 bits when everything above bit 31 is a copy of bit 31.
        if ((v[ACC_W-1:31] == '0) || (v[ACC_W-1:31] == '1))
            return v[31:0];
        else if (v[ACC_W-1])
            return SAT_MIN;
        else
            return SAT_MAX;
`else
        logic unused_hi;
        unused_hi = ^v[ACC_W-1:32];
        return v[31:0];
`endif
    endfunction

endpackage

// File: rtl/fir_mac.sv
// fir_mac -- signed multiply-accumulate datapath.
//   clk, rst : clock, asynchronous active-high reset
//   i_clr    : synchronous clear of the accumulator (wins over i_en)
//   i_en     : add i_weight * i_reff to the accumulator this cycle
//   i_weight : 32-bit signed weight
//   i_reff   : 14-bit signed reference sample
//   o_acc    : 50-bit signed accumulator
module fir_mac
    import fir_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [31:0]      i_weight,
    input  logic [13:0]      i_reff,
    output logic [ACC_W-1:0] o_acc
);

    logic [45:0]      w_wext;
    logic [45:0]      w_rext;
    logic [45:0]      w_prod;
    logic [ACC_W-1:0] r_acc;

    // Sign-extend both operands to the full product width so the low 46 bits
    // of the multiply are the exact signed product.
    assign w_wext = {{14{i_weight[31]}}, i_weight};
    assign w_rext = {{32{i_reff[13]}}, i_reff};
    assign w_prod = $signed(w_wext) * $signed(w_rext);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + {{(ACC_W-46){w_prod[45]}}, w_prod};
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fir_err_calc.sv
// fir_err_calc -- FIR filter output and LMS error calculator.
// Accepts one desired sample per start, walks TAPS weight/reference pairs
// through fir_mac (one tap per cycle), then produces y_out = acc >>> SHIFT and
// e = d_in - y_out, and strobes the weight bank for one cycle.
//   clk, rst         : clock, asynchronous active-high reset
//   start            : one-cycle request, honoured only when idle
//   d_in             : desired sample (signed), latched on accepted start
//   tap_idx          : tap currently addressed in the weight bank
//   weight_rd        : signed weight of tap_idx (combinational from bank)
//   reff_rd          : signed reference sample of tap_idx (combinational)
//   y_out            : registered filter output
//   e                : registered error, stable from UPD until the next ERR
//   weight_cal_state : one-cycle weight-update strobe
//   busy             : high whenever not idle
//   done             : one-cycle pulse with weight_cal_state
// Build option: define FIR_ERR_SAT_EN to saturate y_out and e instead of
// wrapping them to 32 bits.
module fir_err_calc
    import fir_pkg::*;
#(
    parameter int TAPS  = 16,
    parameter int SHIFT = 14
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] d_in,
    output logic [3:0]  tap_idx,
    input  logic [31:0] weight_rd,
    input  logic [13:0] reff_rd,
    output logic [31:0] y_out,
    output logic [31:0] e,
    output logic        weight_cal_state,
    output logic        busy,
    output logic        done
);

    fir_state_t       r_state;
    fir_state_t       w_next;
    logic [3:0]       r_tap;
    logic [31:0]      r_d;
    logic [31:0]      r_y;
    logic [31:0]      r_e;

    logic             w_accept;
    logic             w_last_tap;
    logic             w_mac_en;
    logic [ACC_W-1:0] w_acc;
    logic [ACC_W-1:0] w_acc_sh;
    logic [31:0]      w_y;
    logic [32:0]      w_e_wide;
    logic [31:0]      w_e;

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last_tap = (r_tap == 4'(TAPS - 1));
    assign w_mac_en   = (r_state == S_MAC);

    fir_mac u_mac (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_accept),
        .i_en     (w_mac_en),
        .i_weight (weight_rd),
        .i_reff   (reff_rd),
        .o_acc    (w_acc)
    );

    // Output datapath: the error uses the already-reduced y so that e always
    // equals d - y_out as seen by the weight bank.
    assign w_acc_sh = $signed(w_acc) >>> SHIFT;
    assign w_y      = fir_reduce(w_acc_sh);
    assign w_e_wide = {r_d[31], r_d} - {w_y[31], w_y};
    assign w_e      = fir_reduce({{(ACC_W-33){w_e_wide[32]}}, w_e_wide});

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_MAC;
            S_MAC:   if (w_last_tap) w_next = S_ERR;
            S_ERR:   w_next = S_UPD;
            S_UPD:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // tap_idx only moves in MAC and returns to 0 on the final tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_tap <= '0;
        else if (w_mac_en && !w_last_tap)
            r_tap <= r_tap + 4'd1;
        else
            r_tap <= '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_d <= '0;
        else if (w_accept)
            r_d <= d_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y <= '0;
            r_e <= '0;
        end else if (r_state == S_ERR) begin
            r_y <= w_y;
            r_e <= w_e;
        end
    end

    assign tap_idx          = r_tap;
    assign y_out            = r_y;
    assign e                = r_e;
    assign busy             = (r_state != S_IDLE);
    assign done             = (r_state == S_UPD);
    assign weight_cal_state = (r_state == S_UPD);

endmodule

// File: doc/fir_err_calc.md
FIR_ERR_CALC -- requirements
Module: fir_err_calc

Interface
REQ-001 Parameter TAPS, default 16, number of filter taps; SHALL be a power of two, range 2..16.
REQ-002 Parameter SHIFT, default 14, right-shift applied to the MAC sum before the subtraction.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle request to filter one sample; honoured only in IDLE.
REQ-006 d_in  in  32  desired sample, signed; latched when start is accepted.
REQ-007 tap_idx  out  4  index of the tap whose weight and reference are being read.
REQ-008 weight_rd  in  32  signed weight of tap tap_idx; combinational from the weight bank.
REQ-009 reff_rd  in  14  signed reference sample of tap tap_idx; combinational.
REQ-010 y_out  out  32  signed filter output, registered.
REQ-011 e  out  32  signed error d_in - y_out, registered; drives the weight bank error input.
REQ-012 weight_cal_state  out  1  one-cycle weight-update strobe to the weight bank.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse, coincident with weight_cal_state.

Function
REQ-015 States: IDLE, MAC, ERR, UPD, encoded as a 2-bit FSM.
REQ-016 IDLE, start=1: latch d_in; clear accumulator; tap_idx=0; go to MAC.
REQ-017 IDLE, start=0: hold all registers.
REQ-018 MAC, one tap per cycle: acc += weight_rd*reff_rd, signed 46-bit product, 50-bit accumulator; tap_idx increments.
REQ-019 MAC, tap_idx=TAPS-1: final accumulate; go to ERR.
REQ-020 ERR: y_out = acc >>> SHIFT, arithmetic shift, truncated or saturated to 32 bits per REQ-031.
REQ-021 ERR: e = d_latched - y, computed in 33 bits and reduced to 32 bits per REQ-031; go to UPD.
REQ-022 UPD: weight_cal_state=1 and done=1 for exactly this cycle; go to IDLE.
REQ-023 Latency: start accepted at edge N; done high during cycle N+TAPS+2 (18 cycles at TAPS=16).
REQ-024 e and y_out hold their value from UPD until the next ERR, so the bank samples a stable e.
REQ-025 start while busy is ignored; no queueing.
REQ-026 start in the same cycle as done (UPD) is ignored; earliest accepted start is the following cycle.
REQ-027 tap_idx SHALL hold 0 in IDLE, ERR and UPD.

Reset
REQ-028 rst=1 asynchronously: FSM to IDLE; accumulator, d_latched, y_out, e, tap_idx = 0.
REQ-029 rst=1 asynchronously: weight_cal_state, done, busy = 0.
REQ-030 Reset mid-MAC aborts the sample and produces no weight_cal_state pulse; the first start after rst deasserts is accepted normally.

Configuration
REQ-031 Macro FIR_ERR_SAT_EN selects saturation or wrap for y_out and e.
- Defined: y_out and e saturate to 0x7FFFFFFF / 0x80000000 on overflow.
- Undefined: y_out and e keep the low 32 bits (two's-complement wrap).

Structure
REQ-032 Shared package fir_pkg holds the FSM state typedef, the accumulator width constant (50) and the saturation limit constants.
REQ-033 One sub-module, fir_mac, holds the multiply-accumulate datapath (clear, enable, operands, accumulator out); the FSM stays in the top module.

Verification
REQ-034 SHIFT=0, all weights=1, all reff=1, d_in=20, start -> done at cycle 18, y_out=16, e=4, single weight_cal_state pulse.
REQ-035 Weights=-2, reff=3, d_in=0, SHIFT=0 -> y_out=-96, e=96.
REQ-036 Weights=0x7FFFFFFF, reff=0x1FFF, SHIFT=0:
- FIR_ERR_SAT_EN defined -> y_out=0x7FFFFFFF.
- Undefined -> y_out = low 32 bits of the sum.
REQ-037 start pulsed at cycles 3 and 10 after the first start -> only one done; tap_idx sequence 0..15 uninterrupted.
REQ-038 rst asserted at MAC tap 7 -> busy=0 immediately, no done; the next start gives the correct result from REQ-034 stimulus.
REQ-039 Back-to-back: start on the cycle after done -> second done exactly 18 cycles later; e updated only at ERR.
